// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with byte-lane writes plus LED/TIMER/SCRATCH register window.
// Optional DSRAM_BOUND_CHECK_EN adds an out-of-range check with a sticky bound_err flag.
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        bound_err
);
    localparam int          DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [13:0] OFF_LED     = 14'h0;
    localparam logic [13:0] OFF_TIMER   = 14'h1;
    localparam logic [13:0] OFF_SCRATCH = 14'h2;

    logic [31:0] ram [DEPTH];

    logic [31:0] rdata_reg;
    logic [31:0] timer_reg;
    logic [31:0] scratch_reg;
    logic [15:0] led_reg;
    logic        bound_err_reg;

    logic                  mmio_hit;
    logic                  out_of_range;
    logic                  is_write;
    logic                  ram_wr;
    logic [ADDR_WIDTH-1:0] ram_index;
    logic [13:0]           reg_word;
    logic [31:0]           wr_mask;
    logic [31:0]           timer_merged;
    logic [31:0]           scratch_merged;
    logic [15:0]           led_merged;
    logic [31:0]           reg_rdata;
    logic                  unused_addr_bits;

    assign mmio_hit         = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign ram_index        = data_sram_addr[ADDR_WIDTH+1:2];
    assign reg_word         = data_sram_addr[15:2];
    assign is_write         = |data_sram_we;
    assign unused_addr_bits = ^data_sram_addr[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_mask[8*gi +: 8] = {8{data_sram_we[gi]}};
        end
    endgenerate

    assign timer_merged   = (data_sram_wdata & wr_mask) | (timer_reg & ~wr_mask);
    assign scratch_merged = (data_sram_wdata & wr_mask) | (scratch_reg & ~wr_mask);
    assign led_merged     = (data_sram_wdata[15:0] & wr_mask[15:0]) | (led_reg & ~wr_mask[15:0]);

`ifdef DSRAM_BOUND_CHECK_EN
    assign out_of_range = !mmio_hit && (data_sram_addr[31:ADDR_WIDTH+2] != '0);
`else
    assign out_of_range = 1'b0;
`endif

    // Gating with reset drops a write request sampled while reset is held.
    assign ram_wr = data_sram_en && is_write && !mmio_hit && !out_of_range && !reset;

    always_comb begin
        reg_rdata = '0;
        case (reg_word)
            OFF_LED:     reg_rdata = {16'b0, led_reg};
            OFF_TIMER:   reg_rdata = timer_reg;
            OFF_SCRATCH: reg_rdata = scratch_reg;
            default:     reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    ram[ram_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg     <= '0;
            timer_reg     <= '0;
            scratch_reg   <= '0;
            led_reg       <= '0;
            bound_err_reg <= 1'b0;
        end else begin
            // A timer write replaces this cycle's increment.
            timer_reg <= timer_reg + 32'd1;
            if (data_sram_en) begin
                if (mmio_hit) begin
                    if (is_write) begin
                        case (reg_word)
                            OFF_LED:     led_reg     <= led_merged;
                            OFF_TIMER:   timer_reg   <= timer_merged;
                            OFF_SCRATCH: scratch_reg <= scratch_merged;
                            default:     ;
                        endcase
                    end else begin
                        rdata_reg <= reg_rdata;
                    end
                end else if (out_of_range) begin
                    bound_err_reg <= 1'b1;
                    if (!is_write) begin
                        rdata_reg <= 32'hdead_beef;
                    end
                end else if (!is_write) begin
                    rdata_reg <= ram[ram_index];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_reg;
    assign led             = led_reg;
`ifdef DSRAM_BOUND_CHECK_EN
    assign bound_err = bound_err_reg;
`else
    assign bound_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_data_sram_responder;
    localparam logic [31:0] MMIO = 32'hbfaf_0000;
`ifdef DSRAM_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [3:0]  we    = 4'h0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        bound_err;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .bound_err       (bound_err)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    bit checking = 1'b0;

    // Behavioural model of everything observable
    logic [31:0] m_mem [4096];
    logic [31:0] m_rdata;
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [15:0] m_led;
    logic        m_bound;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_rdata   = '0;
        m_timer   = '0;
        m_scratch = '0;
        m_led     = '0;
        m_bound   = 1'b0;
    endfunction

    function automatic void model_step(input logic e, input logic [3:0] w,
                                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] next_timer;
        logic [31:0] off;
        logic [31:0] full;
        int          idx;
        next_timer = m_timer + 32'd1;
        if (e) begin
            if ((a >> 16) == (MMIO >> 16)) begin
                off = (a % 32'h10000) & ~32'h3;
                if (w != 4'h0) begin
                    if (off == 32'h0) begin
                        full  = merge({16'h0, m_led}, d, {2'b00, w[1:0]});
                        m_led = full[15:0];
                    end else if (off == 32'h4) begin
                        next_timer = merge(m_timer, d, w);
                    end else if (off == 32'h8) begin
                        m_scratch = merge(m_scratch, d, w);
                    end
                end else begin
                    if (off == 32'h0)      m_rdata = {16'h0, m_led};
                    else if (off == 32'h4) m_rdata = m_timer;
                    else if (off == 32'h8) m_rdata = m_scratch;
                    else                   m_rdata = 32'h0;
                end
            end else if (BOUND && a >= 32'h4000) begin
                m_bound = 1'b1;
                if (w == 4'h0) m_rdata = 32'hdead_beef;
            end else begin
                idx = int'((a / 4) % 4096);
                if (w != 4'h0) m_mem[idx] = merge(m_mem[idx], d, w);
                else           m_rdata = m_mem[idx];
            end
        end
        m_timer = next_timer;
    endfunction

    // One request per call; starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        if (e) $display("[TB] t=%0t %s addr=%h we=%h wdata=%h", $time,
                        (w == 4'h0) ? "RD" : "WR", a, w, d);
        @(posedge clk);
        #1;
        model_step(e, w, a, d);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("rdata", rdata, m_rdata);
            check("led", {16'h0, led}, {16'h0, m_led});
            check("bound_err", {31'h0, bound_err}, {31'h0, m_bound});
        end
    end

    logic        r_en;
    logic [3:0]  r_we;
    logic [31:0] r_addr;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_bound", {31'h0, bound_err}, 32'h0);
        checking = 1'b1;

        // Give the exercised RAM region known contents
        for (int wi = 0; wi < 64; wi++) cycle(1'b1, 4'hf, 32'(wi * 4), $urandom);

        cycle(1'b1, 4'hf, 32'h10, 32'h1234_5678);
        cycle(1'b1, 4'h0, 32'h10, 32'h0);
        check("write_read", rdata, 32'h1234_5678);

        cycle(1'b1, 4'hf, 32'h20, 32'hffff_ffff);
        cycle(1'b1, 4'b0101, 32'h20, 32'haabb_ccdd);
        cycle(1'b1, 4'h0, 32'h20, 32'h0);
        check("partial_write", rdata, 32'hffbb_ffdd);

        cycle(1'b1, 4'h0, 32'h10, 32'h0);
        for (int hi = 0; hi < 3; hi++) begin
            cycle(1'b0, 4'h0, 32'h0, 32'h0);
            check("hold_idle", rdata, 32'h1234_5678);
        end
        cycle(1'b1, 4'hf, 32'h30, 32'h0bad_f00d);
        check("hold_write", rdata, 32'h1234_5678);

        cycle(1'b1, 4'hf, MMIO + 32'h4, 32'h0000_0100);
        repeat (5) cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, MMIO + 32'h4, 32'h0);
        check("timer_count", rdata, 32'h0000_0105);
        cycle(1'b1, 4'hf, MMIO + 32'h4, 32'hffff_ffff);
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, MMIO + 32'h4, 32'h0);
        check("timer_wrap", rdata, 32'h0);

        cycle(1'b1, 4'hf, MMIO, 32'hcafe_beef);
        check("led_write", {16'h0, led}, 32'h0000_beef);
        cycle(1'b1, 4'h0, MMIO, 32'h0);
        check("led_read", rdata, 32'h0000_beef);
        cycle(1'b1, 4'h0, MMIO + 32'hc, 32'h0);
        check("mmio_unmapped", rdata, 32'h0);
        cycle(1'b1, 4'hf, MMIO + 32'h8, 32'h1122_3344);
        cycle(1'b1, 4'b1000, MMIO + 32'h8, 32'haa00_0000);
        cycle(1'b1, 4'h0, MMIO + 32'h8, 32'h0);
        check("scratch_merge", rdata, 32'haa22_3344);

`ifdef DSRAM_BOUND_CHECK_EN
        cycle(1'b1, 4'h0, 32'h0001_0000, 32'h0);
        check("oor_read", rdata, 32'hdead_beef);
        check("oor_flag", {31'h0, bound_err}, 32'h1);
        cycle(1'b1, 4'hf, 32'h0001_0010, 32'h5555_5555);
        cycle(1'b1, 4'h0, 32'h10, 32'h0);
        check("oor_write_suppressed", rdata, 32'h1234_5678);
        check("oor_flag_sticky", {31'h0, bound_err}, 32'h1);
`else
        cycle(1'b1, 4'hf, 32'h0000_4010, 32'h55aa_55aa);
        cycle(1'b1, 4'h0, 32'h10, 32'h0);
        check("alias_read", rdata, 32'h55aa_55aa);
        check("no_bound_flag", {31'h0, bound_err}, 32'h0);
`endif

        // Reset lands between a read request and its response edge
        en    = 1'b1;
        we    = 4'h0;
        addr  = 32'h10;
        wdata = 32'h0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("midreset_rdata", rdata, 32'h0);
        check("midreset_led", {16'h0, led}, 32'h0);
        check("midreset_bound", {31'h0, bound_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("after_reset_rdata", rdata, 32'h0);
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, MMIO + 32'h4, 32'h0);
        check("timer_after_reset", rdata, 32'h1);

        for (int n = 0; n < 600; n++) begin
            r_en = ($urandom_range(0, 9) != 0);
            r_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                r_addr = MMIO + 32'($urandom_range(0, 4) * 4);
            end else begin
                r_addr = 32'($urandom_range(0, 63) * 4);
                if (!BOUND || $urandom_range(0, 4) == 0) r_addr = r_addr | ($urandom & 32'hffff_c000);
                if (r_addr[31:16] == MMIO[31:16]) r_addr[31] = ~r_addr[31];
            end
            cycle(r_en, r_we, r_addr, $urandom);
        end
        cycle(1'b0, 4'h0, 32'h0, 32'h0);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
